ddr2_frame_wr_rd: RTL and testbench
===================================

// Module: ddr2_frame_wr_rd
// PURPOSE
//  Avalon-MM master toward the DDR2 controller local interface.
//  Packs a stream of 16-bit samples into 64-bit words and writes one frame to DDR2.
//  Then issues the read requests for the same frame, so local_rdata/local_rdata_valid
//  return to the peak-search reader in address order.
//  Lane order matches the reader: first sample -> [15:0], fourth -> [63:48].
// PARAMETERS
//  ADDR_W       24    local_address width (64-bit word address)
//  FRAME_WORDS  1000  64-bit words per frame (4*FRAME_WORDS samples), >=2
//  BASE_ADDR    0     word address of frame word 0
// PORTS
//  phy_clk           in   1       controller PHY clock, all logic rising edge
//  reset_phy_clk_n   in   1       asynchronous active-low reset
//  local_init_done   in   1       DDR2 calibration complete
//  local_ready       in   1       controller accepts request this cycle
//  start             in   1       1-cycle pulse: begin one frame write+read
//  smp_data          in   16      sample in
//  smp_valid         in   1       smp_data valid
//  smp_ready         out  1       sample accepted when smp_valid&&smp_ready
//  local_address     out  ADDR_W  request word address
//  local_write_req   out  1       write request
//  local_read_req    out  1       read request
//  local_burstbegin  out  1       =local_write_req|local_read_req (size-1 bursts)
//  local_wdata       out  64      packed write data
//  local_be          out  8       constant 8'hFF
//  local_size        out  1       constant 1'b1
//  busy              out  1       state != IDLE
//  frame_done        out  1       1-cycle pulse after last read request accepted
// BEHAVIOUR
//  Reset: all outputs 0 except local_be=8'hFF, local_size=1; state IDLE; lane=0, widx=0.
//  Request accepted on a cycle with (write_req|read_req) && local_ready.
//  While a request is pending and not accepted: req, address, wdata held stable.
//  FSM:
//   IDLE:  start && local_init_done -> FILL; widx=0. start otherwise ignored.
//   FILL:  smp_ready=1. Each accepted sample goes to lane[lane]; lane++.
//          On 4th sample (lane==3) -> WRITE next cycle with write_req=1,
//          address=BASE_ADDR+widx.
//   WRITE: smp_ready=0. On accept:
//          widx==FRAME_WORDS-1 -> READ, widx=0, read_req=1, address=BASE_ADDR.
//          else widx++ and -> FILL. write_req low the cycle after accept.
//   READ:  read_req held high; each accept -> address++, widx++.
//          On accept with widx==FRAME_WORDS-1 -> DONE; read_req low next cycle.
//          Back-to-back reads: no wait on local_rdata_valid.
//   DONE:  frame_done=1 for exactly one cycle -> IDLE.
//  start while busy: ignored.
//  local_init_done low in FILL/WRITE/READ: next cycle -> IDLE.
//   Requests drop, partial lane data discarded, no frame_done, widx/lane cleared.
//  Address = BASE_ADDR+widx, widx 0..FRAME_WORDS-1; wraps to 0 at start of read
//   phase and of every frame. Address arithmetic truncated to ADDR_W.
//  Asynchronous reset mid-operation: immediate return to reset values.
//   No request completes.
//  Throughput: at most 1 write per 5 cycles (4 fill + 1 write);
//   reads 1/cycle when local_ready=1.
// TESTING
//  1 init_done=1, start, ramp 0..3999 continuous, ready=1 ->
//    1000 writes; word k addr k, wdata={4k+3,4k+2,4k+1,4k}.
//    Then 1000 reads addr 0..999 on consecutive cycles; one frame_done.
//  2 local_ready=0 for 5 cycles while word 10 pending ->
//    write_req, addr=10, wdata held stable; smp_ready=0; word 10 written exactly once.
//  3 smp_valid toggled 1-of-3 cycles -> same wdata as test 1, no sample lost or duplicated.
//  4 local_init_done drops at read 500 ->
//    read_req=0 next cycle, busy=0, no frame_done.
//    A new start then begins at addr 0 with write.
//  5 start while busy, and start with init_done=0 ->
//    no effect on state, address or counters.
//  6 reset_phy_clk_n low mid-WRITE with ready=0 ->
//    write_req=0 in the same cycle (asynchronous), all outputs at reset values.

Source files
------------

// File: rtl/ddr2_frame_wr_rd.sv
// ddr2_frame_wr_rd
//   Avalon-MM master toward the DDR2 controller local interface. Packs 16-bit
//   samples four at a time into 64-bit words (first sample in [15:0]), writes
//   one frame of FRAME_WORDS words starting at BASE_ADDR, then issues
//   back-to-back single-word reads over the same frame so the read data comes
//   back to the downstream reader in address order.
//
//   Ports
//     phy_clk, reset_phy_clk_n      controller clock, async active-low reset
//     local_init_done, local_ready  controller calibration done / accept
//     start                         1-cycle pulse, begins one frame write+read
//     smp_data, smp_valid, smp_ready  sample stream handshake
//     local_address, local_write_req, local_read_req, local_burstbegin,
//     local_wdata, local_be, local_size   controller request bus
//     busy                          FSM not idle
//     frame_done                    1-cycle pulse after last read accepted
//
//   state | meaning
//   IDLE  | waiting for start with calibration done
//   FILL  | collecting four samples into the next word
//   WRITE | write request pending for word widx
//   READ  | read requests issued, one per accepted cycle
//   DONE  | frame_done pulse, then back to IDLE
module ddr2_frame_wr_rd #(
  parameter int ADDR_W      = 24,
  parameter int FRAME_WORDS = 1000,
  parameter int BASE_ADDR   = 0
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              local_init_done,
  input  logic              local_ready,
  input  logic              start,
  input  logic [15:0]       smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [63:0]       local_wdata,
  output logic [7:0]        local_be,
  output logic              local_size,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, READ, DONE} state_t;

  localparam int                WIDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [1:0]        lane;
  logic [WIDX_W-1:0] widx;
  logic [47:0]       wbuf;   // lanes 0..2; lane 3 goes straight into local_wdata
  logic              active;

  assign active           = (state == FILL) || (state == WRITE) || (state == READ);
  assign local_burstbegin = local_write_req | local_read_req;
  assign local_be         = 8'hFF;
  assign local_size       = 1'b1;
  assign busy             = (state != IDLE);

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state           <= IDLE;
      lane            <= '0;
      widx            <= '0;
      wbuf            <= '0;
      smp_ready       <= 1'b0;
      local_address   <= '0;
      local_write_req <= 1'b0;
      local_read_req  <= 1'b0;
      local_wdata     <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (active && !local_init_done) begin
        // Calibration lost: abandon the frame, drop any pending request.
        state           <= IDLE;
        lane            <= '0;
        widx            <= '0;
        wbuf            <= '0;
        smp_ready       <= 1'b0;
        local_write_req <= 1'b0;
        local_read_req  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && local_init_done) begin
              state     <= FILL;
              widx      <= '0;
              lane      <= '0;
              smp_ready <= 1'b1;
            end
          end
          FILL: begin
            if (smp_valid && smp_ready) begin
              lane <= lane + 2'd1;
              case (lane)
                2'd0: wbuf[15:0]  <= smp_data;
                2'd1: wbuf[31:16] <= smp_data;
                2'd2: wbuf[47:32] <= smp_data;
                default: begin
                  local_wdata     <= {smp_data, wbuf};
                  local_address   <= BASE + ADDR_W'(widx);
                  local_write_req <= 1'b1;
                  smp_ready       <= 1'b0;
                  state           <= WRITE;
                end
              endcase
            end
          end
          WRITE: begin
            if (local_ready) begin
              local_write_req <= 1'b0;
              if (widx == LAST_WIDX) begin
                state          <= READ;
                widx           <= '0;
                local_read_req <= 1'b1;
                local_address  <= BASE;
              end else begin
                widx      <= widx + WIDX_W'(1);
                state     <= FILL;
                smp_ready <= 1'b1;
              end
            end
          end
          READ: begin
            if (local_ready) begin
              if (widx == LAST_WIDX) begin
                local_read_req <= 1'b0;
                state          <= DONE;
                frame_done     <= 1'b1;
              end else begin
                widx          <= widx + WIDX_W'(1);
                local_address <= local_address + ADDR_W'(1);
              end
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr2_frame_wr_rd.sv
module tb_ddr2_frame_wr_rd;
  localparam int ADDR_W = 24;
  localparam int FW     = 1000;

  logic              phy_clk = 1'b0;
  logic              reset_phy_clk_n = 1'b0;
  logic              local_init_done = 1'b0;
  logic              local_ready = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       smp_data = '0;
  logic              smp_valid = 1'b0;
  logic              smp_ready;
  logic [ADDR_W-1:0] local_address;
  logic              local_write_req;
  logic              local_read_req;
  logic              local_burstbegin;
  logic [63:0]       local_wdata;
  logic [7:0]        local_be;
  logic              local_size;
  logic              busy;
  logic              frame_done;

  ddr2_frame_wr_rd #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW), .BASE_ADDR(0)) dut (
    .phy_clk(phy_clk), .reset_phy_clk_n(reset_phy_clk_n),
    .local_init_done(local_init_done), .local_ready(local_ready), .start(start),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .local_address(local_address), .local_write_req(local_write_req),
    .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
    .local_wdata(local_wdata), .local_be(local_be), .local_size(local_size),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 phy_clk = ~phy_clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } wr_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int first_rd = -1;
  int last_rd  = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word_of(input int k);
    return {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
  endfunction

  // Monitor: pops the scoreboard on every accepted request.
  initial begin
    wr_t               e;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge phy_clk);
      cyc++;
      if (reset_phy_clk_n) begin
        if (frame_done) done_cnt++;
        if (local_write_req && local_ready) begin
          check("wr_burstbegin", 64'(local_burstbegin), 64'd1);
          if (exp_wr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: addr %0h expected no write", local_address);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(local_address), 64'(e.addr));
            check("wr_data", local_wdata, e.data);
          end
        end
        if (local_read_req && local_ready) begin
          check("rd_burstbegin", 64'(local_burstbegin), 64'd1);
          if (exp_rd.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_read: addr %0h expected no read", local_address);
          end else begin
            a = exp_rd.pop_front();
            check("rd_addr", 64'(local_address), 64'(a));
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
          end
        end
      end
    end
  end

  task automatic feed(input int n, input int period, input int budget);
    int   s = 0;
    int   k = 0;
    logic acc;
    while (s < n && k < budget) begin
      smp_valid = ((k % period) == 0);
      smp_data  = 16'(s);
      @(negedge phy_clk);
      acc = smp_valid && smp_ready;
      @(posedge phy_clk); #1;
      if (acc) s++;
      k++;
    end
    smp_valid = 1'b0;
    check("samples_fed", 64'(s), 64'(n));
  endtask

  task automatic control(input int stall_word, input int abort_rd, input bit poke,
                         input int budget, input int done0, output bit aborted);
    int k = 0;
    bit stalled = 0, poked_w = 0, poked_r = 0;
    bit do_stall, do_abort, do_pw, do_pr;
    aborted = 0;
    while (done_cnt == done0 && !aborted && k < budget) begin
      @(negedge phy_clk);
      do_stall = stall_word >= 0 && !stalled && smp_valid && smp_ready &&
                 smp_data == 16'(4*stall_word+3);
      do_abort = abort_rd > 0 && local_read_req && local_ready &&
                 local_address == ADDR_W'(abort_rd-1);
      do_pw = poke && !poked_w && local_write_req && local_address == ADDR_W'(20);
      do_pr = poke && !poked_r && local_read_req && local_address == ADDR_W'(300);
      @(posedge phy_clk); #1;
      k++;
      if (do_pw || do_pr) begin
        if (do_pw) poked_w = 1; else poked_r = 1;
        start = 1'b1;
        @(posedge phy_clk); #1;
        start = 1'b0;
        k++;
      end
      if (do_stall) begin
        stalled = 1;
        local_ready = 1'b0;
        repeat (5) begin
          @(negedge phy_clk);
          check("stall_wreq", 64'(local_write_req), 64'd1);
          check("stall_addr", 64'(local_address), 64'(stall_word));
          check("stall_wdata", local_wdata, word_of(stall_word));
          check("stall_smp_ready", 64'(smp_ready), 64'd0);
          @(posedge phy_clk); #1;
          k++;
        end
        local_ready = 1'b1;
      end
      if (do_abort) begin
        aborted = 1;
        local_init_done = 1'b0;
        local_ready = 1'b0;
        @(negedge phy_clk);
        @(negedge phy_clk);
        check("abort_rreq", 64'(local_read_req), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge phy_clk); #1;
        local_init_done = 1'b1;
        local_ready = 1'b1;
        repeat (10) @(posedge phy_clk);
        #1;
      end
    end
  endtask

  task automatic run_frame(input int period, input int stall_word, input int abort_rd, input bit poke);
    int done0 = done_cnt;
    int nrd   = (abort_rd > 0) ? abort_rd : FW;
    int budget = (4*period + 2)*FW + FW + 200;
    bit aborted;
    exp_wr.delete(); exp_rd.delete();
    first_rd = -1; last_rd = -1;
    for (int k = 0; k < FW; k++) exp_wr.push_back('{addr: ADDR_W'(k), data: word_of(k)});
    for (int k = 0; k < nrd; k++) exp_rd.push_back(ADDR_W'(k));
    start = 1'b1;
    @(posedge phy_clk); #1;
    start = 1'b0;
    fork
      feed(4*FW, period, 4*FW*period + 20*FW);
      control(stall_word, abort_rd, poke, budget, done0, aborted);
    join
    repeat (3) @(posedge phy_clk);
    #1;
    check("aborted", 64'(aborted), 64'(abort_rd > 0));
    check("done_count", 64'(done_cnt - done0), aborted ? 64'd0 : 64'd1);
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("rd_left", 64'(exp_rd.size()), 64'd0);
    if (!aborted) check("rd_span", 64'(last_rd - first_rd), 64'(FW-1));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wreq"}, 64'(local_write_req), 64'd0);
    check({tag, "_rreq"}, 64'(local_read_req), 64'd0);
    check({tag, "_burst"}, 64'(local_burstbegin), 64'd0);
    check({tag, "_smp_ready"}, 64'(smp_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd0);
    check({tag, "_addr"}, 64'(local_address), 64'd0);
    check({tag, "_wdata"}, local_wdata, 64'd0);
    check({tag, "_be"}, 64'(local_be), 64'hFF);
    check({tag, "_size"}, 64'(local_size), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge phy_clk);
    #1;
    check_reset_values("reset");
    @(negedge phy_clk);
    reset_phy_clk_n = 1'b1;
    @(posedge phy_clk); #1;

    // start ignored while calibration is not done
    start = 1'b1;
    @(posedge phy_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge phy_clk);
    #1;
    check("nocal_busy", 64'(busy), 64'd0);
    check("nocal_smp_ready", 64'(smp_ready), 64'd0);
    check("nocal_wreq", 64'(local_write_req), 64'd0);
    local_init_done = 1'b1;
    local_ready = 1'b1;
    repeat (2) @(posedge phy_clk);
    #1;
    check("nocal_busy_late", 64'(busy), 64'd0);

    run_frame(1, -1, -1, 1'b1);   // full frame, with stray starts while busy
    run_frame(1, 10, -1, 1'b0);   // controller stall on word 10
    run_frame(1, -1, 500, 1'b0);  // calibration loss at read 500
    run_frame(3, -1, -1, 1'b0);   // sparse samples, fresh frame after abort

    // async reset while a write is stalled
    local_ready = 1'b0;
    start = 1'b1;
    @(posedge phy_clk); #1;
    start = 1'b0;
    feed(4, 1, 50);
    check("rst_wreq_pending", 64'(local_write_req), 64'd1);
    check("rst_addr_pending", 64'(local_address), 64'd0);
    #2;
    reset_phy_clk_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge phy_clk);
    reset_phy_clk_n = 1'b1;
    local_ready = 1'b1;
    repeat (3) @(posedge phy_clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
